// File: rtl/cbus_single_arbiter.sv
// rtl/cbus_single_arbiter.sv - single-beat ibus/dbus to cbus arbiter and bridge (option: CBUS_ARB_RR_EN)
package common;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;
    typedef logic [2:0]  msize_t;
    typedef logic [7:0]  mlen_t;
    typedef logic [1:0]  axi_burst_type_t;

    localparam msize_t          MSIZE4         = 3'b010;
    localparam mlen_t           MLEN1          = 8'h00;
    localparam axi_burst_type_t AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        addr_t           addr;
        strobe_t         strobe;
        word_t           data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;
endpackage

module cbus_single_arbiter
    import common::*;
(
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    cbus_req_t  r_creq;
    cbus_req_t  w_xlate;
    logic       w_any_req;
    logic       w_grant_d;
    logic       w_done;
    logic       w_busy;

    assign w_any_req = ireq.valid | dreq.valid;
    assign w_done    = cresp.ready & cresp.last;
    assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);

`ifdef CBUS_ARB_RR_EN
    logic r_last_d;

    // On contention, hand the bus to whichever port did not win last time.
    always_comb begin
        w_grant_d = dreq.valid;
        if (dreq.valid && ireq.valid) begin
            w_grant_d = ~r_last_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && w_any_req) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    // Loads/stores are older than the fetch, so they always win.
    assign w_grant_d = dreq.valid;
`endif

    always_comb begin
        w_xlate       = '0;
        w_xlate.valid = 1'b1;
        w_xlate.len   = MLEN1;
        w_xlate.burst = AXI_BURST_INCR;
        if (w_grant_d) begin
            w_xlate.is_write = |dreq.strobe;
            w_xlate.size     = dreq.size;
            w_xlate.addr     = dreq.addr;
            w_xlate.strobe   = dreq.strobe;
            w_xlate.data     = dreq.data;
        end else begin
            w_xlate.size = MSIZE4;
            w_xlate.addr = ireq.addr;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_next = w_grant_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_creq  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_any_req) begin
                r_creq <= w_xlate;
            end
        end
    end

    assign creq = w_busy ? r_creq : '0;

    always_comb begin
        iresp = '0;
        dresp = '0;
        if (w_done && r_state == BUSY_I) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = r_creq.addr[2] ? cresp.data[63:32] : cresp.data[31:0];
        end
        if (w_done && r_state == BUSY_D) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = cresp.data;
        end
    end
endmodule

// File: doc/cbus_single_arbiter.md
# cbus_single_arbiter

Single-beat arbiter and protocol bridge between the core's instruction bus (`ibus_req_t`/`ibus_resp_t`) and data bus (`dbus_req_t`/`dbus_resp_t`) and one shared cache bus (`cbus_req_t`/`cbus_resp_t`). It sits directly downstream of the pipeline's fetch and memory stages, on the uncached path to the AXI adapter. It grants one requester at a time and converts the request into a one-beat cbus transaction. It then returns the read data, or the write completion, to the granted requester.

## Interface
Parameters:
- none; all widths come from package `common`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ireq`  in  `ibus_req_t` (65)  fetch request; addr is 4-byte aligned.
- `iresp`  out  `ibus_resp_t` (34)  fetch response.
- `dreq`  in  `dbus_req_t` (140)  load/store request.
- `dresp`  out  `dbus_resp_t` (66)  load/store response.
- `creq`  out  `cbus_req_t` (151)  shared bus request.
- `cresp`  in  `cbus_resp_t` (66)  shared bus response.

## Operation
The FSM has three states: `IDLE`, `BUSY_I`, `BUSY_D`.

`IDLE`:
- `creq.valid` = 0.
- If `dreq.valid` or `ireq.valid` is high, arbitrate (see Configuration).
- Latch the translated request into the `creq` register.
- Go to `BUSY_D` or `BUSY_I` according to the grant.

Translation of an ibus request:
- `is_write` = 0, `size` = `MSIZE4`, `addr` = `ireq.addr`, `strobe` = 0, `data` = 0.
- `len` = `MLEN1`, `burst` = `AXI_BURST_INCR`.

Translation of a dbus request:
- `is_write` = `|dreq.strobe`.
- `size`, `addr`, `strobe`, `data` are copied from `dreq`.
- `len` = `MLEN1`, `burst` = `AXI_BURST_INCR`.

`BUSY_x`:
- `creq` is driven from the registered request with `valid` = 1, held stable until completion.
- Completion is `cresp.ready && cresp.last`. In that same cycle, combinationally:
  - Granted port: `addr_ok` = `data_ok` = 1.
  - Data: `dresp.data` = `cresp.data`. `iresp.data` = latched `addr[2]` ? `cresp.data[63:32]` : `cresp.data[31:0]`.
  - Next state is `IDLE`.
- `cresp.ready && !cresp.last` is ignored; the FSM stays busy.

Output rules:
- The non-granted port's `addr_ok`/`data_ok` are always 0.
- All `*resp` fields are 0 whenever `addr_ok` is 0.

Requester contract:
- The requester holds `valid` and its payload stable until `data_ok`.
- If `valid` drops while busy, the transaction still completes and the response pulse is issued and discarded.
- The request changes made after the grant are not observed.

Reset:
- Asynchronous: state goes to `IDLE` and `creq` to all-zero immediately, including mid-transaction.
- The in-flight response is lost. The requester must re-issue.

## Timing
- Request sampled in `IDLE` at cycle 0; `creq.valid` is high from cycle 1.
- If the first `ready && last` arrives in cycle k ≥ 1, the response is in cycle k. Minimum latency is 1 cycle.
- Back-to-back: cycle k+1 is `IDLE` and arbitrates. The next `creq.valid` is at k+2, so there is one idle bus cycle between transactions.
- `cresp` is ignored in `IDLE`.
- Reset values of outputs: `creq` = 0, `iresp` = 0, `dresp` = 0.
- A request arriving during busy waits, with no response, until the FSM returns to `IDLE`.

## Configuration
- Macro `CBUS_ARB_RR_EN`.
  - Undefined: fixed priority. dbus wins whenever both are valid in `IDLE`. Memory ops belong to older instructions, so this avoids fetch starving a stalled load.
  - Defined: round-robin. A 1-bit `last_grant` register (reset = ibus) updates on every grant. When both are valid, grant the port not granted last. A single valid requester is always granted.

## Test plan
- Ifetch: `ireq` addr `0x8000_0004`, `cresp.data` = `0x1111_2222_3333_4444` with ready+last at cycle 3.
  - `creq`: `{valid=1, is_write=0, size=MSIZE4, len=MLEN1}` from cycle 1.
  - `iresp.data` = `0x1111_2222` at cycle 3, `data_ok` for exactly one cycle.
- Store: `dreq` addr `0x1f2`, `strobe` = `0b0000_0100`, data `0x00cd_0000`.
  - `creq.is_write` = 1 with payload copied.
  - `dresp.data_ok` = 1 on ready+last.
  - `iresp` remains 0.
- Contention: `ireq` and `dreq` both valid for 3 back-to-back transactions.
  - Without `CBUS_ARB_RR_EN`: D,D,D while dreq stays valid.
  - With `CBUS_ARB_RR_EN`: D,I,D.
- Beat filtering: `ready=1, last=0` at cycle 2, then `ready=1, last=1` at cycle 4.
  - No response at cycle 2.
  - Response only at cycle 4 with the cycle-4 data.
- Reset mid-op: assert `reset` in `BUSY_D` between cycles.
  - `creq.valid` = 0 without waiting for a clock edge.
  - After release, a fresh `dreq` completes normally.
- Requester abandons: `dreq.valid` drops in cycle 2 while busy.
  - `creq` stays valid and stable until ready+last.
  - `dresp.data_ok` still pulses once.
